// File: rtl/pc_sequencer.sv
// Program-counter stage plus Enter push-button conditioning for the decoder.
// Latency: pc/pc_fault update one cycle after the controls; enter_pulse fires 2+DEBOUNCE_CYCLES+1 cycles after a stable press.
// Backpressure: none; pc_write=0 freezes the pc and the debouncer runs freely. Optional bounds check: `define PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
  parameter int ADDR_W           = 10,
  parameter int RESET_PC         = 0,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int ENTER_ACTIVE_LOW = 1
`ifdef PC_BOUNDS_CHECK_EN
  ,
  parameter int MEM_DEPTH        = 1 << ADDR_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enter_btn,
  input  logic              pc_write,
  input  logic [1:0]        jump,
  input  logic              branch,
  input  logic              bne,
  input  logic              alu_zero,
  input  logic [15:0]       imm,
  input  logic [25:0]       jump_target,
  input  logic [31:0]       jr_addr,
  output logic              enter_pulse,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
`ifdef PC_BOUNDS_CHECK_EN
  ,
  output logic              pc_fault
`endif
);

  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);
  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  ARM_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  HELD_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic              RELEASED   = (ENTER_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_FIRE,
    ST_HELD
  } db_state_t;

  logic [31:0]       imm_sx;
  logic              taken;
  logic [ADDR_W-1:0] next_pc;
  logic              sync1;
  logic              sync2;
  logic              pressed;
  db_state_t         db_state;
  logic [CNT_W-1:0]  db_cnt;

  // Upper instruction-field bits never reach a word address of this width.
  logic unused_bits;
  assign unused_bits = ^{jump_target[25:ADDR_W], jr_addr[31:ADDR_W], imm_sx[31:ADDR_W]};

  assign imm_sx   = {{16{imm[15]}}, imm};
  assign pc_plus1 = pc + ADDR_W'(1);
  assign taken    = (branch & alu_zero) | (bne & ~alu_zero);

  // Next-address select: absolute jumps win over a taken branch, else fall through.
  always_comb begin
    next_pc = pc_plus1;
    case (jump)
      2'b01:   next_pc = jump_target[ADDR_W-1:0];
      2'b10:   next_pc = jr_addr[ADDR_W-1:0];
      default: next_pc = taken ? (pc_plus1 + imm_sx[ADDR_W-1:0]) : pc_plus1;
    endcase
  end

`ifdef PC_BOUNDS_CHECK_EN
  logic out_of_range;
  assign out_of_range = ({1'b0, next_pc} >= (ADDR_W + 1)'(MEM_DEPTH));

  // PC register; an out-of-range target freezes the pc for good and latches the fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC_L;
      pc_fault <= 1'b0;
    end else if (pc_write && !pc_fault) begin
      if (out_of_range) begin
        pc_fault <= 1'b1;
      end else begin
        pc <= next_pc;
      end
    end
  end
`else
  // PC register; advances only when the decoder allows it, wrapping silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC_L;
    end else if (pc_write) begin
      pc <= next_pc;
    end
  end
`endif

  // Two-flop synchronizer for the asynchronous button, reset to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
    end else begin
      sync1 <= enter_btn;
      sync2 <= sync1;
    end
  end

  assign pressed = (ENTER_ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Debounce FSM: one pulse per accepted press, re-armed only after a stable release.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_state    <= ST_IDLE;
      db_cnt      <= '0;
      enter_pulse <= 1'b0;
    end else begin
      enter_pulse <= 1'b0;
      case (db_state)
        ST_IDLE: begin
          db_cnt <= '0;
          if (pressed) begin
            db_state <= ST_ARMING;
            db_cnt   <= CNT_W'(1);
          end
        end
        ST_ARMING: begin
          if (!pressed) begin
            db_state <= ST_IDLE;
            db_cnt   <= '0;
          end else if (db_cnt == ARM_MAX) begin
            db_state    <= ST_FIRE;
            db_cnt      <= '0;
            enter_pulse <= 1'b1;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        ST_FIRE: begin
          db_state <= ST_HELD;
          db_cnt   <= '0;
        end
        ST_HELD: begin
          if (pressed) begin
            db_cnt <= '0;
          end else if (db_cnt == HELD_MAX) begin
            db_state <= ST_IDLE;
            db_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + CNT_W'(1);
          end
        end
        default: begin
          db_state <= ST_IDLE;
          db_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized traffic.
// Reference model works from address arithmetic and press/release run lengths.
// Outputs are sampled 1 time unit after each rising edge.
module tb_pc_sequencer;

  localparam int AW   = 10;
  localparam int DB   = 4;
  localparam int MASK = (1 << AW) - 1;
  localparam int MEMD = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter_btn;
  logic        pc_write;
  logic [1:0]  jump;
  logic        branch;
  logic        bne;
  logic        alu_zero;
  logic [15:0] imm;
  logic [25:0] jump_target;
  logic [31:0] jr_addr;
  logic        enter_pulse;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus1;
`ifdef PC_BOUNDS_CHECK_EN
  logic        pc_fault;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_pc;
  bit m_pulse;
  bit m_fault;
  bit m_s1, m_s2;          // pressed level as seen through the two sync stages
  bit m_armed, m_skip;
  int m_hi, m_lo;

  pc_sequencer #(
    .ADDR_W(AW),
    .RESET_PC(0),
    .DEBOUNCE_CYCLES(DB),
    .ENTER_ACTIVE_LOW(1)
`ifdef PC_BOUNDS_CHECK_EN
    ,
    .MEM_DEPTH(MEMD)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .enter_btn(enter_btn),
    .pc_write(pc_write),
    .jump(jump),
    .branch(branch),
    .bne(bne),
    .alu_zero(alu_zero),
    .imm(imm),
    .jump_target(jump_target),
    .jr_addr(jr_addr),
    .enter_pulse(enter_pulse),
    .pc(pc),
    .pc_plus1(pc_plus1)
`ifdef PC_BOUNDS_CHECK_EN
    ,
    .pc_fault(pc_fault)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    int nxt;
    bit p;
    bit tk;
    if (reset) begin
      m_pc = 0; m_pulse = 0; m_fault = 0;
      m_s1 = 0; m_s2 = 0;
      m_armed = 1; m_skip = 0; m_hi = 0; m_lo = 0;
    end else begin
      tk = (branch && alu_zero) || (bne && !alu_zero);
      if (jump == 2'b01)      nxt = int'(jump_target) & MASK;
      else if (jump == 2'b10) nxt = int'(jr_addr[AW-1:0]);
      else if (tk)            nxt = (m_pc + 1 + int'($signed(imm))) & MASK;
      else                    nxt = (m_pc + 1) & MASK;
      if (pc_write) begin
`ifdef PC_BOUNDS_CHECK_EN
        if (!m_fault) begin
          if (nxt >= MEMD) m_fault = 1;
          else m_pc = nxt;
        end
`else
        m_pc = nxt;
`endif
      end
      // debounce: N+1 consecutive pressed samples while armed fire one pulse;
      // after a pulse, one ignored sample then N consecutive released samples re-arm.
      p = m_s2;
      m_s2 = m_s1;
      m_s1 = ~enter_btn;
      m_pulse = 0;
      if (m_armed) begin
        m_hi = p ? m_hi + 1 : 0;
        if (m_hi == DB + 1) begin
          m_pulse = 1; m_armed = 0; m_skip = 1; m_lo = 0;
        end
      end else if (m_skip) begin
        m_skip = 0;
      end else begin
        m_lo = p ? 0 : m_lo + 1;
        if (m_lo == DB) begin
          m_armed = 1; m_hi = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_eq("pc", 32'(pc), 32'(m_pc));
    check_eq("pc_plus1", 32'(pc_plus1), 32'((m_pc + 1) & MASK));
    check_eq("enter_pulse", 32'(enter_pulse), 32'(m_pulse));
`ifdef PC_BOUNDS_CHECK_EN
    check_eq("pc_fault", 32'(pc_fault), 32'(m_fault));
`endif
  endtask

  task automatic set_ctl(input logic pw, input logic [1:0] j, input logic b, input logic n,
                         input logic z, input logic [15:0] im);
    pc_write = pw; jump = j; branch = b; bne = n; alu_zero = z; imm = im;
  endtask

  task automatic jump_to(input int addr);
    set_ctl(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0);
    jump_target = 26'(addr);
    step();
  endtask

  task automatic run_count(input int n, output int pulses, output int first_at);
    pulses = 0; first_at = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (enter_pulse) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
  endtask

  initial begin
    int pulses, at, run_left;
    reset = 1'b1; enter_btn = 1'b1;
    set_ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
    jump_target = '0; jr_addr = '0;
    step(); step();
    check_eq("reset_pc", 32'(pc), 32'd0);
    check_eq("reset_pulse", 32'(enter_pulse), 32'd0);
    reset = 1'b0;

    // sequential fetch
    for (int i = 1; i <= 4; i++) begin
      step();
      check_eq("seq_pc", 32'(pc), 32'(i));
    end

    // branches from pc=20
    jump_to(20);
    set_ctl(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 16'hFFFB); step();
    check_eq("beq_taken", 32'(pc), 32'd16);
    jump_to(20);
    set_ctl(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'hFFFB); step();
    check_eq("beq_not_taken", 32'(pc), 32'd21);
    jump_to(20);
    set_ctl(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0003); step();
    check_eq("bne_taken", 32'(pc), 32'd24);

    // absolute jumps and pc_write gating
    jump_to(32'h155);
`ifndef PC_BOUNDS_CHECK_EN
    check_eq("j_target", 32'(pc), 32'h155);
`endif
    set_ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0); jr_addr = 32'h0000_0007; step();
`ifndef PC_BOUNDS_CHECK_EN
    check_eq("jr_target", 32'(pc), 32'd7);
`endif
    set_ctl(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0); jump_target = 26'h3FF; step();
`ifndef PC_BOUNDS_CHECK_EN
    check_eq("hold_no_write", 32'(pc), 32'd7);
`endif

    // debounce: short bounce, then a held press
    set_ctl(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
    enter_btn = 1'b0; step(); step();
    enter_btn = 1'b1; step();
    enter_btn = 1'b0;
    run_count(20, pulses, at);
    check_eq("press_pulses", 32'(pulses), 32'd1);
    check_eq("press_latency", 32'(at), 32'(2 + DB + 1));
    enter_btn = 1'b1; run_count(12, pulses, at);
    check_eq("release_pulses", 32'(pulses), 32'd0);
    enter_btn = 1'b0; run_count(20, pulses, at);
    check_eq("repress_pulses", 32'(pulses), 32'd1);

    // reset while arming aborts the press
    enter_btn = 1'b1; run_count(12, pulses, at);
    enter_btn = 1'b0; step(); step(); step(); step();
    reset = 1'b1; enter_btn = 1'b1; step();
    check_eq("rst_arm_pc", 32'(pc), 32'd0);
    check_eq("rst_arm_pulse", 32'(enter_pulse), 32'd0);
    reset = 1'b0;
    run_count(12, pulses, at);
    check_eq("rst_arm_no_pulse", 32'(pulses), 32'd0);

`ifdef PC_BOUNDS_CHECK_EN
    reset = 1'b1; step(); reset = 1'b0;
    jump_to(31);
    set_ctl(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0); step();
    check_eq("bounds_pc_hold", 32'(pc), 32'd31);
    check_eq("bounds_fault", 32'(pc_fault), 32'd1);
    jump_to(5);
    check_eq("bounds_sticky_pc", 32'(pc), 32'd31);
    check_eq("bounds_sticky_fault", 32'(pc_fault), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("bounds_clear", 32'(pc_fault), 32'd0);
`endif

    // randomized traffic against the model
    run_left = 1;
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      pc_write = ($urandom_range(0, 3) != 0);
      jump = 2'($urandom_range(0, 3));
      branch = 1'($urandom);
      bne = 1'($urandom);
      alu_zero = 1'($urandom);
      imm = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 16)) - 8);
      jump_target = 26'($urandom);
      jr_addr = $urandom;
      run_left--;
      if (run_left == 0) begin
        enter_btn = ~enter_btn;
        run_left = $urandom_range(1, 2 * DB + 2);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
